// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port grant/sequencer for the single-ported vector data memory
// Optional starvation guard (forced host slot) enabled by `DMEM_ARB_STARVE_GUARD_EN
module dmem_arbiter #(
  parameter int vecSize      = 4,
  parameter int registerSize = 8,
  parameter int starveLimit  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pipe_req,
  input  logic                             pipe_we,
  input  logic [registerSize-1:0]          pipe_addr,
  input  logic [vecSize*registerSize-1:0]  pipe_wdata,
  output logic                             pipe_stall,
  output logic                             pipe_rvalid,
  output logic [vecSize*registerSize-1:0]  pipe_rdata,
  input  logic                             host_req,
  input  logic                             host_we,
  input  logic [registerSize-1:0]          host_addr,
  input  logic [vecSize*registerSize-1:0]  host_wdata,
  output logic                             host_gnt,
  output logic                             host_rvalid,
  output logic [vecSize*registerSize-1:0]  host_rdata,
  output logic                             mem_we,
  output logic [registerSize-1:0]          mem_addr,
  output logic [vecSize*registerSize-1:0]  mem_wdata,
  input  logic [vecSize*registerSize-1:0]  mem_rdata
);
  typedef enum logic {PIPE_PRI, HOST_FORCE} state_t;
  typedef enum logic [1:0] {NONE, PIPE, HOST} owner_t;
  state_t state, state_nxt;
  owner_t owner, owner_nxt;
  logic pipe_gnt;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  logic [3:0] starve_cnt, starve_nxt;
`endif
  always_comb begin
    host_gnt = (state == HOST_FORCE) ? host_req : host_req & ~pipe_req;
    pipe_gnt = (state == HOST_FORCE) ? pipe_req & ~host_req : pipe_req;
    pipe_stall = pipe_req & ~pipe_gnt;
    mem_we = pipe_gnt ? pipe_we : host_gnt & host_we;
    mem_addr = pipe_gnt ? pipe_addr : host_gnt ? host_addr : '0;
    mem_wdata = pipe_gnt ? pipe_wdata : host_gnt ? host_wdata : '0;
    owner_nxt = (pipe_gnt & ~pipe_we) ? PIPE : (host_gnt & ~host_we) ? HOST : NONE;
    // a return still pending while reset is held is suppressed
    pipe_rvalid = (owner == PIPE) & ~reset;
    host_rvalid = (owner == HOST) & ~reset;
    pipe_rdata = pipe_rvalid ? mem_rdata : '0;
    host_rdata = host_rvalid ? mem_rdata : '0;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    starve_nxt = ~(host_req & ~host_gnt) ? 4'd0 :
                 (starve_cnt == 4'(starveLimit)) ? starve_cnt : starve_cnt + 4'd1;
    state_nxt = (state == HOST_FORCE) ? PIPE_PRI :
                (starve_nxt == 4'(starveLimit)) ? HOST_FORCE : PIPE_PRI;
`else
    state_nxt = PIPE_PRI;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PIPE_PRI;
      owner <= NONE;
`ifdef DMEM_ARB_STARVE_GUARD_EN
      starve_cnt <= 4'd0;
`endif
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
`ifdef DMEM_ARB_STARVE_GUARD_EN
      starve_cnt <= starve_nxt;
`endif
    end
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the vector data memory in the writeback stage. The pipeline's load/store port and a host/loader port share one single-ported `data_memory`. The block grants one requester per cycle and drives the memory's write-enable, address and write data. It returns the synchronous read data one cycle later, tagged to the requester that issued the read. The pipeline normally has priority; a starvation guard forces a host slot so image loading and readback make progress during long pipeline runs.

## Interface
- `vecSize`, 4, lanes per memory word
- `registerSize`, 8, bits per lane; also the address width
- `starveLimit`, 4, consecutive denied host cycles before a forced host grant (range 1..15)

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `pipe_req`  in  1  pipeline access request
- `pipe_we`  in  1  pipeline write (1) or read (0)
- `pipe_addr`  in  registerSize  pipeline address
- `pipe_wdata`  in  vecSize×registerSize  pipeline write vector
- `pipe_stall`  out  1  pipeline request not granted this cycle; pipeline holds all inputs
- `pipe_rvalid`  out  1  `pipe_rdata` valid
- `pipe_rdata`  out  vecSize×registerSize  read vector returned to the pipeline
- `host_req`  in  1  host access request; held until granted
- `host_we`  in  1  host write (1) or read (0)
- `host_addr`  in  registerSize  host address
- `host_wdata`  in  vecSize×registerSize  host write vector
- `host_gnt`  out  1  host request accepted this cycle
- `host_rvalid`  out  1  `host_rdata` valid
- `host_rdata`  out  vecSize×registerSize  read vector returned to the host
- `mem_we`  out  1  to `data_memory` write_enable
- `mem_addr`  out  registerSize  to `data_memory` DataAdr
- `mem_wdata`  out  vecSize×registerSize  to `data_memory` toWrite_data
- `mem_rdata`  in  vecSize×registerSize  from `data_memory` read_data (1-cycle synchronous read)

## Operation
- FSM states:
  - `PIPE_PRI` (reset state): the pipeline wins any conflict.
  - `HOST_FORCE`: the host wins any conflict.
- Grant logic is combinational from the current requests and FSM state.
  - `PIPE_PRI`: `pipe_gnt = pipe_req`; `host_gnt = host_req & ~pipe_req`.
  - `HOST_FORCE`: `host_gnt = host_req`; `pipe_gnt = pipe_req & ~host_req`.
  - `pipe_stall = pipe_req & ~pipe_gnt`.
- Memory drive:
  - `mem_we`, `mem_addr` and `mem_wdata` come from the granted requester.
  - When nothing is granted: `mem_we=0`, `mem_addr=0`, `mem_wdata=0`.
  - `mem_we` is never asserted without a grant.
- Starvation counter `starve_cnt` (4 bits):
  - Increments on each cycle with `host_req & ~host_gnt`.
  - Clears to 0 on `host_gnt` or when `host_req=0`.
  - Saturates at `starveLimit`.
- FSM transitions:
  - `PIPE_PRI → HOST_FORCE` when `starve_cnt == starveLimit` at the clock edge.
  - `HOST_FORCE → PIPE_PRI` after exactly one host grant, or immediately if `host_req` has dropped.
- Read return:
  - A registered owner tag (`NONE`/`PIPE`/`HOST`) captures the granted requester for reads only (`gnt & ~we`).
  - Next cycle, the owner's `rvalid=1` and its `rdata = mem_rdata`.
  - The non-owner's `rdata` is 0.
  - Writes produce no `rvalid`.
- Simultaneous events:
  - A read grant and the previous cycle's read return overlap freely, giving one access per cycle with full throughput.
  - Same-address write then read on consecutive cycles returns the new data, because `data_memory` ordering is preserved.

## Timing
- Grant and `pipe_stall` take 0 cycles (same cycle as the request).
- Read data arrives 1 cycle after the grant. Writes commit at the grant edge.
- Reset values:
  - `pipe_rvalid=0`, `host_rvalid=0`, `pipe_rdata=0`, `host_rdata=0`.
  - Owner tag `NONE`, `starve_cnt=0`, FSM `PIPE_PRI`.
  - `pipe_stall`, `host_gnt` and `mem_*` follow their combinational rules once requests are low (all 0).
- Reset asserted mid-read: the pending return is dropped, and no `rvalid` is asserted in the cycle after reset releases.
- Worst-case host wait under continuous pipeline traffic is `starveLimit+1` cycles. Worst-case pipeline stall per forced slot is 1 cycle.

## Configuration
- `DMEM_ARB_STARVE_GUARD_EN` defined: the starvation counter and the `HOST_FORCE` state are compiled in, as described above.
- Not defined: strict pipeline priority. The FSM stays in `PIPE_PRI`, `starve_cnt` is absent, and the host waits indefinitely while `pipe_req=1`.

## Test plan
- Reset, then host write of addr 0x10 data {1,2,3,4}, then host read of 0x10 → `host_gnt=1` each cycle; one cycle after the read, `host_rvalid=1`, `host_rdata={1,2,3,4}`, `pipe_rvalid=0`.
- Pipeline read of 0x20 and host read of 0x30 in the same cycle → pipeline granted, `pipe_stall=0`, host denied; next cycle `pipe_rvalid=1`; host granted in that cycle; `host_rvalid=1` one cycle later.
- Starve guard, `starveLimit=4`, `pipe_req` and `host_req` held high:
  - Host denied for 4 cycles.
  - Cycle 5: `host_gnt=1`, `pipe_stall=1`.
  - Cycle 6: pipeline granted again and `starve_cnt=0`.
  - Without the macro, the host is never granted across 20 cycles.
- Back-to-back pipeline reads of 0x01, 0x02, 0x03 → `pipe_rvalid` high for 3 consecutive cycles, with data in address order.
- Host read granted, then `reset=1` on the next cycle → no `host_rvalid`; all outputs read 0 with requests low.
- Pipeline write of 0x05 = {9,9,9,9}, then host read of 0x05 next cycle → `host_rdata={9,9,9,9}`.
